fpu_issuer: RTL and testbench
=============================

// Module: fpu_issuer
// PURPOSE
//   Requester side of the fpu start/done interface. Takes operation requests
//   (A, B, op) from a host over valid/ready, presents operands to the FPU, pulses
//   start, waits for done, captures R and queues it in a small result FIFO that the
//   host drains over valid/ready. A watchdog turns a hung FPU into a flagged qNaN.
//   Sits between the datapath/host sequencer and the fpu instance.
// PARAMETERS
//   TIMEOUT    200   max WAIT cycles before the op is aborted (1..2^TO_W-1)
//   TO_W       8     watchdog counter width
//   RSP_DEPTH  2     result FIFO entries (power of 2, >=2)
// PORTS
//   clk          in   1   system clock, all state on rising edge
//   rst          in   1   asynchronous, active-high reset
//   req_valid    in   1   host request valid
//   req_ready    out  1   issuer can accept a request this cycle
//   req_a        in   32  operand A (IEEE-754 single)
//   req_b        in   32  operand B
//   req_op       in   2   operation code, passed through unchanged (00 add, else mult)
//   rsp_valid    out  1   FIFO head valid
//   rsp_ready    in   1   host pops FIFO head
//   rsp_r        out  32  FIFO head result
//   rsp_timeout  out  1   FIFO head was produced by watchdog abort
//   fpu_a        out  32  registered operand A to FPU
//   fpu_b        out  32  registered operand B to FPU
//   fpu_op       out  2   registered op to FPU
//   fpu_start    out  1   start pulse to FPU (registered)
//   fpu_done     in   1   FPU completion
//   fpu_r        in   32  FPU result, valid while fpu_done=1
//   busy         out  1   state != IDLE
//   to_count     out  8   saturating count of watchdog aborts
// BEHAVIOUR
//   Reset (async): state=IDLE, fpu_a/b/op=0, fpu_start=0, FIFO empty (rsp_valid=0,
//     rsp_r=0, rsp_timeout=0), watchdog=0, to_count=0, busy=0. fpu_start drops
//     immediately on rst even mid-pulse; an in-flight op is discarded, never reported.
//   FSM: IDLE -> LOAD -> LAUNCH -> WAIT -> IDLE.
//   - IDLE: req_ready = (fifo_count < RSP_DEPTH). Accept on req_valid&req_ready:
//     latch req_a/b/op into fpu_a/b/op, go LOAD. req_ready=0 in every other state.
//   - LOAD: 1 cycle; operands stable at FPU before start rises (FPU is start-edge
//     triggered). Next LAUNCH.
//   - LAUNCH: fpu_start=1 for exactly this one cycle; watchdog cleared. Next WAIT.
//     fpu_done is ignored in LOAD/LAUNCH (stale done from previous op).
//   - WAIT: watchdog +1 per cycle. If fpu_done=1: push {fpu_r, timeout=0}, go IDLE.
//     Else if watchdog == TIMEOUT-1: push {32'h7FC00000, timeout=1}, to_count+1
//     (saturates at 255), go IDLE. done and timeout same cycle: done wins.
//   - fpu_a/b/op hold their value after the op until next acceptance.
//   Latency: accept at edge 0 -> fpu_start high cycle 2 -> done sampled at edge k ->
//     rsp_valid=1 from cycle k+1 (FIFO empty case). Minimum accept-to-accept = 4 cycles.
//   FIFO: first-word-fall-through; rsp_r/rsp_timeout show head when rsp_valid=1.
//     Pop on rsp_valid&rsp_ready. Push+pop same cycle: count unchanged, order kept.
//     Push never overflows: acceptance requires a free slot and at most one op is in flight.
//     Pointers wrap modulo RSP_DEPTH. Pop while empty is ignored.
//   Sign/exponent/op content is never interpreted; the issuer is data-agnostic.
// TESTING (bench uses behavioural FPU model with programmable done delay)
//   1) A=3F800000 B=40000000 op=00, done after 3 cycles with R=40400000 -> fpu_start
//      single pulse in cycle 2, rsp_valid with rsp_r=40400000, rsp_timeout=0.
//   2) Model never asserts done -> after TIMEOUT WAIT cycles rsp_r=7FC00000,
//      rsp_timeout=1, to_count=1, state IDLE; a following op completes normally.
//   3) rsp_ready=0, three back-to-back requests -> two results queued, req_ready=0
//      with fifo full, third accepted only after one pop; order preserved.
//   4) done asserted in LOAD/LAUNCH and again in WAIT -> exactly one result pushed,
//      taken from WAIT-cycle fpu_r.
//   5) rst asserted during WAIT -> fpu_start=0, busy=0, rsp_valid=0 at once; late
//      fpu_done after release produces no result.
//   6) done on exact timeout cycle -> normal result, rsp_timeout=0, to_count unchanged.

Source files
------------

// File: rtl/fpu_issuer_if.sv
// Host/FPU bundle seen by the fpu_issuer.
// slave is the issuer side, master is the host plus FPU side.
interface fpu_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_r;
    logic        rsp_timeout;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_op;
    logic        fpu_start;
    logic        fpu_done;
    logic [31:0] fpu_r;
    logic        busy;
    logic [7:0]  to_count;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        input  fpu_done, fpu_r,
        output req_ready, rsp_valid, rsp_r, rsp_timeout,
        output fpu_a, fpu_b, fpu_op, fpu_start, busy, to_count
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        output fpu_done, fpu_r,
        input  req_ready, rsp_valid, rsp_r, rsp_timeout,
        input  fpu_a, fpu_b, fpu_op, fpu_start, busy, to_count
    );
endinterface

// File: rtl/fpu_issuer.sv
// Requester for the FPU start/done port: issues one op at a time,
// queues results in a small FWFT FIFO, watchdog turns a hang into a qNaN.
module fpu_issuer #(
    parameter int TIMEOUT   = 200,
    parameter int TO_W      = 8,
    parameter int RSP_DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    fpu_issuer_if.slave bus
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [31:0]     QNAN    = 32'h7FC00000;
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [PW:0]     FULL    = (PW+1)'(RSP_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, LAUNCH, WAIT} state_t;

    state_t          state;
    logic [TO_W-1:0] wdog;
    logic [31:0]     aQ;
    logic [31:0]     bQ;
    logic [1:0]      opQ;
    logic            startQ;
    logic [7:0]      toCnt;

    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [PW:0]     count;
    logic [31:0]     memR  [RSP_DEPTH];
    logic            memTo [RSP_DEPTH];

    logic        accept;
    logic        doneHit;
    logic        abortHit;
    logic        push;
    logic        pop;
    logic [31:0] pushR;

    assign bus.req_ready = (state == IDLE) && (count < FULL);
    assign accept   = bus.req_valid && bus.req_ready;
    // done outside WAIT is a stale pulse from the previous op
    assign doneHit  = (state == WAIT) && bus.fpu_done;
    assign abortHit = (state == WAIT) && !bus.fpu_done && (wdog == WD_LAST);
    assign push     = doneHit || abortHit;
    assign pop      = (count != '0) && bus.rsp_ready;
    assign pushR    = doneHit ? bus.fpu_r : QNAN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wdog   <= '0;
            aQ     <= '0;
            bQ     <= '0;
            opQ    <= '0;
            startQ <= 1'b0;
            toCnt  <= '0;
        end else begin
            startQ <= (state == LOAD);
            if (abortHit && toCnt != 8'hFF) toCnt <= toCnt + 8'd1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        aQ    <= bus.req_a;
                        bQ    <= bus.req_b;
                        opQ   <= bus.req_op;
                        state <= LOAD;
                    end
                end
                LOAD: state <= LAUNCH;
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (push) state <= IDLE;
                    else      wdog  <= wdog + TO_W'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memR[wrPtr]  <= pushR;
            memTo[wrPtr] <= abortHit;
        end
    end

    assign bus.rsp_valid   = (count != '0);
    assign bus.rsp_r       = bus.rsp_valid ? memR[rdPtr] : '0;
    assign bus.rsp_timeout = bus.rsp_valid && memTo[rdPtr];
    assign bus.fpu_a       = aQ;
    assign bus.fpu_b       = bQ;
    assign bus.fpu_op      = opQ;
    assign bus.fpu_start   = startQ;
    assign bus.busy        = (state != IDLE);
    assign bus.to_count    = toCnt;
endmodule

// File: tb/tb_fpu_issuer.sv
// Bench for fpu_issuer: behavioural FPU with per-op done delay,
// directed scenarios plus a randomized scoreboard run.
module tb_fpu_issuer;
    localparam int TO = 20;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct {
        int          dly;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [1:0]  op;
    } job_t;

    typedef struct {
        logic [31:0] r;
        logic        t;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_issuer_if bus();

    fpu_issuer #(
        .TIMEOUT(TO),
        .TO_W(8),
        .RSP_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int nCmp  = 0;
    int nBad  = 0;
    int refTo = 0;

    bit          modelEn   = 1'b1;
    logic        modelDone = 1'b0;
    logic [31:0] modelR    = '0;
    logic        manDone   = 1'b0;
    logic [31:0] manR      = '0;

    assign bus.fpu_done = modelEn ? modelDone : manDone;
    assign bus.fpu_r    = modelEn ? modelR : manR;

    // FPU model: each start consumes one job; done pulses dly cycles later
    job_t modelQ[$];
    job_t cur;
    int   cnt   = 0;
    bit   armed = 1'b0;

    always @(negedge clk) begin
        modelDone = 1'b0;
        if (armed) begin
            cnt--;
            if (cnt == 0) begin
                modelDone = 1'b1;
                modelR    = cur.r;
                armed     = 1'b0;
            end
        end
        if (bus.fpu_start && modelQ.size() != 0) begin
            cur = modelQ.pop_front();
            nCmp++;
            if ({bus.fpu_a, bus.fpu_b, bus.fpu_op} !== {cur.a, cur.b, cur.op}) begin
                nBad++;
                $display("FAIL fpu_operands: got %h/%h/%h want %h/%h/%h",
                         bus.fpu_a, bus.fpu_b, bus.fpu_op, cur.a, cur.b, cur.op);
            end
            if (cur.dly > 0) begin
                armed = 1'b1;
                cnt   = cur.dly;
            end
        end
    end

    task automatic issue(input job_t j, output bit ok);
        ok = 1'b0;
        if (modelEn) modelQ.push_back(j);
        bus.req_a     = j.a;
        bus.req_b     = j.b;
        bus.req_op    = j.op;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.req_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic waitRsp(input int budget, output bit got, output int cyc);
        cyc = 0;
        while (!bus.rsp_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        got = bus.rsp_valid;
    endtask

    task automatic popOne(output logic [31:0] r, output logic t);
        r = bus.rsp_r;
        t = bus.rsp_timeout;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    function automatic job_t rndJob(input int dly);
        job_t j;
        j.dly = dly;
        j.a   = $urandom;
        j.b   = $urandom;
        j.r   = $urandom;
        j.op  = 2'($urandom_range(0, 3));
        return j;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nCmp++;
        if ({bus.fpu_start, bus.busy, bus.rsp_valid, bus.rsp_timeout} !== 4'b0) begin
            nBad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.fpu_start, bus.busy, bus.rsp_valid, bus.rsp_timeout});
        end
        nCmp++;
        if ({bus.fpu_a, bus.fpu_b, bus.fpu_op, bus.rsp_r, bus.to_count} !== '0) begin
            nBad++;
            $display("FAIL reset_data: got a=%h b=%h op=%h r=%h to=%0d want all 0",
                     bus.fpu_a, bus.fpu_b, bus.fpu_op, bus.rsp_r, bus.to_count);
        end
        rst = 1'b0;
        @(negedge clk);
        nCmp++;
        if (bus.req_ready !== 1'b1) begin
            nBad++;
            $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        refTo = 0;
    endtask

    task automatic test_basic();
        job_t        j;
        bit          ok;
        int          pulses = 0;
        int          firstStart = 0;
        int          rspCyc = 0;
        logic [31:0] r;
        logic        t;
        modelEn = 1'b1;
        j = '{dly: 3, a: 32'h3F800000, b: 32'h40000000, r: 32'h40400000, op: 2'b00};
        issue(j, ok);
        nCmp++;
        if (!ok) begin nBad++; $display("FAIL basic_accept: got 0 want 1"); end
        for (int c = 1; c <= 12; c++) begin
            if (bus.fpu_start) begin
                pulses++;
                if (firstStart == 0) firstStart = c;
            end
            if (bus.rsp_valid && rspCyc == 0) rspCyc = c;
            @(negedge clk);
        end
        nCmp++;
        if (pulses != 1 || firstStart != 2) begin
            nBad++;
            $display("FAIL basic_start: got %0d pulses at cycle %0d want 1 at 2",
                     pulses, firstStart);
        end
        nCmp++;
        if (rspCyc != 6) begin
            nBad++;
            $display("FAIL basic_latency: got cycle %0d want 6", rspCyc);
        end
        nCmp++;
        if (bus.rsp_r !== 32'h40400000 || bus.rsp_timeout !== 1'b0) begin
            nBad++;
            $display("FAIL basic_result: got %h/%b want 40400000/0",
                     bus.rsp_r, bus.rsp_timeout);
        end
        nCmp++;
        if (bus.fpu_a !== 32'h3F800000 || bus.fpu_b !== 32'h40000000 || bus.busy !== 1'b0) begin
            nBad++;
            $display("FAIL basic_hold: got a=%h b=%h busy=%b want 3F800000/40000000/0",
                     bus.fpu_a, bus.fpu_b, bus.busy);
        end
        popOne(r, t);
        nCmp++;
        if (bus.rsp_valid !== 1'b0) begin
            nBad++;
            $display("FAIL basic_pop: got rsp_valid=%b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_timeout();
        job_t        j;
        bit          ok;
        bit          got;
        int          cyc;
        logic [31:0] r;
        logic        t;
        modelEn = 1'b1;
        j = rndJob(0);
        issue(j, ok);
        waitRsp(TO + 20, got, cyc);
        nCmp++;
        if (!ok || !got || cyc != TO + 2) begin
            nBad++;
            $display("FAIL timeout_latency: got ok=%b rsp=%b after %0d want 1/1 after %0d",
                     ok, got, cyc, TO + 2);
        end
        refTo++;
        nCmp++;
        if (bus.rsp_r !== QNAN || bus.rsp_timeout !== 1'b1 || bus.busy !== 1'b0) begin
            nBad++;
            $display("FAIL timeout_result: got %h/%b busy=%b want 7fc00000/1/0",
                     bus.rsp_r, bus.rsp_timeout, bus.busy);
        end
        nCmp++;
        if (bus.to_count !== 8'(refTo)) begin
            nBad++;
            $display("FAIL timeout_count: got %0d want %0d", bus.to_count, refTo);
        end
        popOne(r, t);
        j = rndJob(2);
        issue(j, ok);
        waitRsp(20, got, cyc);
        popOne(r, t);
        nCmp++;
        if (!got || r !== j.r || t !== 1'b0 || bus.to_count !== 8'(refTo)) begin
            nBad++;
            $display("FAIL timeout_recover: got %b %h/%b to=%0d want 1 %h/0 to=%0d",
                     got, r, t, bus.to_count, j.r, refTo);
        end
    endtask

    task automatic test_back_to_back();
        job_t        j1, j2, j3;
        bit          ok1, ok2, ok3;
        bit          got;
        bit          sawReady = 1'b0;
        int          cyc;
        logic [31:0] r;
        logic        t;
        modelEn = 1'b1;
        bus.rsp_ready = 1'b0;
        j1 = rndJob(2);
        j2 = rndJob(3);
        j3 = rndJob(1);
        issue(j1, ok1);
        issue(j2, ok2);
        bus.req_a     = j3.a;
        bus.req_b     = j3.b;
        bus.req_op    = j3.op;
        bus.req_valid = 1'b1;
        repeat (30) begin
            if (bus.req_ready) sawReady = 1'b1;
            @(negedge clk);
        end
        nCmp++;
        if (!ok1 || !ok2 || sawReady || bus.rsp_valid !== 1'b1) begin
            nBad++;
            $display("FAIL full_block: got ok=%b%b ready_seen=%b rsp=%b want 11 0 1",
                     ok1, ok2, sawReady, bus.rsp_valid);
        end
        popOne(r, t);
        nCmp++;
        if (r !== j1.r || t !== 1'b0) begin
            nBad++;
            $display("FAIL order_1: got %h/%b want %h/0", r, t, j1.r);
        end
        issue(j3, ok3);
        waitRsp(20, got, cyc);
        popOne(r, t);
        nCmp++;
        if (!ok3 || !got || r !== j2.r) begin
            nBad++;
            $display("FAIL order_2: got ok=%b %h want 1 %h", ok3, r, j2.r);
        end
        waitRsp(20, got, cyc);
        popOne(r, t);
        nCmp++;
        if (!got || r !== j3.r || bus.rsp_valid !== 1'b0) begin
            nBad++;
            $display("FAIL order_3: got %b %h rsp=%b want 1 %h 0",
                     got, r, bus.rsp_valid, j3.r);
        end
    endtask

    task automatic test_stale_done();
        job_t        j;
        bit          ok;
        bit          extra = 1'b0;
        logic [31:0] good;
        logic [31:0] r;
        logic        t;
        modelEn = 1'b0;
        j = rndJob(1);
        good = $urandom;
        issue(j, ok);
        manDone = 1'b1;
        manR    = 32'hDEAD0001;
        @(negedge clk);
        manR    = 32'hDEAD0002;
        nCmp++;
        if (!ok || bus.fpu_start !== 1'b1) begin
            nBad++;
            $display("FAIL stale_launch: got ok=%b start=%b want 1/1", ok, bus.fpu_start);
        end
        @(negedge clk);
        manDone = 1'b0;
        nCmp++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
            nBad++;
            $display("FAIL stale_ignored: got rsp=%b busy=%b want 0/1",
                     bus.rsp_valid, bus.busy);
        end
        @(negedge clk);
        manDone = 1'b1;
        manR    = good;
        @(negedge clk);
        manDone = 1'b0;
        manR    = 32'hDEAD0003;
        nCmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_r !== good || bus.rsp_timeout !== 1'b0) begin
            nBad++;
            $display("FAIL stale_result: got %b %h/%b want 1 %h/0",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_timeout, good);
        end
        popOne(r, t);
        repeat (5) begin
            if (bus.rsp_valid) extra = 1'b1;
            @(negedge clk);
        end
        nCmp++;
        if (extra) begin
            nBad++;
            $display("FAIL stale_single: got extra result want none");
        end
        modelEn = 1'b1;
    endtask

    task automatic test_done_at_timeout();
        job_t        j;
        bit          ok;
        logic [31:0] good;
        logic [31:0] r;
        logic        t;
        modelEn = 1'b0;
        j = rndJob(1);
        good = $urandom;
        issue(j, ok);
        repeat (TO + 1) @(negedge clk);
        nCmp++;
        if (!ok || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
            nBad++;
            $display("FAIL edge_pending: got ok=%b rsp=%b busy=%b want 1/0/1",
                     ok, bus.rsp_valid, bus.busy);
        end
        manDone = 1'b1;
        manR    = good;
        @(negedge clk);
        manDone = 1'b0;
        nCmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_r !== good || bus.rsp_timeout !== 1'b0) begin
            nBad++;
            $display("FAIL edge_result: got %b %h/%b want 1 %h/0",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_timeout, good);
        end
        nCmp++;
        if (bus.to_count !== 8'(refTo)) begin
            nBad++;
            $display("FAIL edge_count: got %0d want %0d", bus.to_count, refTo);
        end
        popOne(r, t);
        modelEn = 1'b1;
    endtask

    task automatic test_reset_mid();
        job_t j;
        bit   ok1, ok2;
        bit   got;
        bit   late = 1'b0;
        int   cyc;
        modelEn = 1'b1;
        j = rndJob(2);
        issue(j, ok1);
        waitRsp(20, got, cyc);
        j = rndJob(8);
        issue(j, ok2);
        repeat (3) @(negedge clk);
        nCmp++;
        if (!ok1 || !ok2 || !got || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b1) begin
            nBad++;
            $display("FAIL rst_setup: got %b%b%b busy=%b rsp=%b want 111 1 1",
                     ok1, ok2, got, bus.busy, bus.rsp_valid);
        end
        #2 rst = 1'b1;
        #1;
        nCmp++;
        if ({bus.fpu_start, bus.busy, bus.rsp_valid, bus.to_count} !== '0) begin
            nBad++;
            $display("FAIL rst_wait: got start=%b busy=%b rsp=%b to=%0d want 0",
                     bus.fpu_start, bus.busy, bus.rsp_valid, bus.to_count);
        end
        refTo = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            if (bus.rsp_valid || bus.busy) late = 1'b1;
            @(negedge clk);
        end
        nCmp++;
        if (late) begin
            nBad++;
            $display("FAIL rst_late_done: got result or busy after reset want none");
        end
        j = rndJob(3);
        issue(j, ok1);
        @(negedge clk);
        nCmp++;
        if (!ok1 || bus.fpu_start !== 1'b1) begin
            nBad++;
            $display("FAIL rst_launch_setup: got ok=%b start=%b want 1/1", ok1, bus.fpu_start);
        end
        #2 rst = 1'b1;
        #1;
        nCmp++;
        if (bus.fpu_start !== 1'b0 || bus.busy !== 1'b0) begin
            nBad++;
            $display("FAIL rst_launch: got start=%b busy=%b want 0/0", bus.fpu_start, bus.busy);
        end
        @(negedge clk);
        rst  = 1'b0;
        late = 1'b0;
        repeat (10) begin
            if (bus.rsp_valid || bus.busy) late = 1'b1;
            @(negedge clk);
        end
        nCmp++;
        if (late || bus.req_ready !== 1'b1) begin
            nBad++;
            $display("FAIL rst_launch_after: got late=%b ready=%b want 0/1", late, bus.req_ready);
        end
    endtask

    task automatic test_random();
        res_t exp[$];
        res_t e;
        job_t j;
        int   acc = 0;
        int   n   = 30;
        modelEn = 1'b1;
        for (int c = 0; c < 4000 && (acc < n || exp.size() != 0 || bus.busy); c++) begin
            @(negedge clk);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            if (bus.rsp_valid && bus.rsp_ready) begin
                nCmp++;
                if (exp.size() == 0) begin
                    nBad++;
                    $display("FAIL rnd_extra: got %h/%b want no result",
                             bus.rsp_r, bus.rsp_timeout);
                end else begin
                    e = exp.pop_front();
                    if (bus.rsp_r !== e.r || bus.rsp_timeout !== e.t) begin
                        nBad++;
                        $display("FAIL rnd_result: got %h/%b want %h/%b",
                                 bus.rsp_r, bus.rsp_timeout, e.r, e.t);
                    end
                end
            end
            j = rndJob(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)));
            bus.req_valid = (acc < n) && ($urandom_range(0, 2) != 0);
            bus.req_a     = j.a;
            bus.req_b     = j.b;
            bus.req_op    = j.op;
            if (bus.req_valid && bus.req_ready) begin
                modelQ.push_back(j);
                e.r = (j.dly == 0) ? QNAN : j.r;
                e.t = (j.dly == 0);
                exp.push_back(e);
                if (j.dly == 0) refTo++;
                acc++;
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        nCmp++;
        if (acc != n || exp.size() != 0) begin
            nBad++;
            $display("FAIL rnd_drain: got %0d accepted %0d pending want %0d/0",
                     acc, exp.size(), n);
        end
        nCmp++;
        if (bus.to_count !== 8'(refTo)) begin
            nBad++;
            $display("FAIL rnd_to_count: got %0d want %0d", bus.to_count, refTo);
        end
    endtask

    initial begin
        #500000;
        nBad++;
        $display("FAIL global_timeout: got no finish want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_timeout();
        test_back_to_back();
        test_stale_done();
        test_done_at_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
